truth_sweep_ctrl: RTL and testbench

Sequencer that exhaustively drives every input combination of a K-input combinational logic block. It compares the block's reference output against its Karnaugh-reduced output on each vector and reports mismatch statistics. It sits between a start/abort control source and the `ej9`-style combinational datapath: its `vec` output drives the datapath inputs, and the two compared function outputs return on `ref_in` and `dut_in`. It replaces an open-ended stimulus loop with a clocked, self-checking sweep.

---
 rtl/truth_sweep_ctrl.sv | 146 ++++++++++++++
 tb/tb_truth_sweep_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/truth_sweep_ctrl.sv
// truth_sweep_ctrl: drives every K-bit input vector of a combinational block
// in ascending order. Each vector is held for SETTLE cycles. On the last of
// those cycles the reference and reduced outputs are compared, and the sweep
// accumulates minterm and mismatch statistics.
module truth_sweep_ctrl #(
   parameter int K      = 5,
   parameter int SETTLE = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         abort,
   output logic [K-1:0] vec,
   input  logic         ref_in,
   input  logic         dut_in,
   output logic         busy,
   output logic         done,
   output logic [K:0]   mismatch_cnt,
   output logic [K:0]   ones_cnt,
   output logic         any_bad,
   output logic [K-1:0] first_bad
);

   // The wait counter needs at least one bit, even when SETTLE is 1.
   localparam int WW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [WW-1:0] WAIT_INIT = WW'(SETTLE - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [K-1:0]   vec_q, vec_d;
   logic [WW-1:0]  wait_q, wait_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic [K:0]     mismatch_q, mismatch_d;
   logic [K:0]     ones_q, ones_d;
   logic           any_bad_q, any_bad_d;
   logic [K-1:0]   first_bad_q, first_bad_d;

   // State and datapath registers; reset returns everything to an idle, cleared sweep.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         vec_q       <= '0;
         wait_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         mismatch_q  <= '0;
         ones_q      <= '0;
         any_bad_q   <= 1'b0;
         first_bad_q <= '0;
      end else begin
         state_q     <= state_d;
         vec_q       <= vec_d;
         wait_q      <= wait_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         mismatch_q  <= mismatch_d;
         ones_q      <= ones_d;
         any_bad_q   <= any_bad_d;
         first_bad_q <= first_bad_d;
      end
   end

   // Next-state logic. busy/done are computed one cycle ahead so the outputs stay registered.
   always_comb begin
      state_d     = state_q;
      vec_d       = vec_q;
      wait_d      = wait_q;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      mismatch_d  = mismatch_q;
      ones_d      = ones_q;
      any_bad_d   = any_bad_q;
      first_bad_d = first_bad_q;

      case (state_q)
         ST_IDLE: begin
            vec_d = '0;
            if (start && !abort) begin
               state_d     = ST_RUN;
               busy_d      = 1'b1;
               wait_d      = WAIT_INIT;
               mismatch_d  = '0;
               ones_d      = '0;
               any_bad_d   = 1'b0;
               first_bad_d = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (abort) begin
               // Abort wins over the sample; partial totals stay visible.
               state_d = ST_IDLE;
               vec_d   = '0;
            end else if (wait_q != '0) begin
               busy_d = 1'b1;
               wait_d = wait_q - WW'(1);
            end else begin
               ones_d = ones_q + {{K{1'b0}}, ref_in};
               if (ref_in != dut_in) begin
                  mismatch_d = mismatch_q + (K+1)'(1);
                  if (!any_bad_q) begin
                     any_bad_d   = 1'b1;
                     first_bad_d = vec_q;
                  end else begin
                     any_bad_d   = any_bad_q;
                  end
               end else begin
                  mismatch_d = mismatch_q;
               end
               if (&vec_q) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  busy_d = 1'b1;
                  vec_d  = vec_q + K'(1);
                  wait_d = WAIT_INIT;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            vec_d   = '0;
         end
         default: begin
            state_d = ST_IDLE;
            vec_d   = '0;
         end
      endcase
   end

   assign vec          = vec_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign mismatch_cnt = mismatch_q;
   assign ones_cnt     = ones_q;
   assign any_bad      = any_bad_q;
   assign first_bad    = first_bad_q;

endmodule

// File: tb/tb_truth_sweep_ctrl.sv
// Directed bench for truth_sweep_ctrl. One instance uses SETTLE=1 and the
// other uses SETTLE=3. The bench models the datapath as a selectable function
// of vec.
module tb_truth_sweep_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       start1, abort1, start3, abort3;
   logic [4:0] vec1, vec3, first_bad1, first_bad3;
   logic       ref1, dut1, ref3, dut3;
   logic       busy1, done1, any_bad1, busy3, done3, any_bad3;
   logic [5:0] mis1, ones1, mis3, ones3;
   int         mode1, mode3;
   int         n_checks = 0;
   int         n_fail = 0;

   always #5 clk = ~clk;

   // Datapath model: mode 0 is a clean pair, mode 1 corrupts vector 19 and mode 2 is always wrong.
   function automatic logic f_ref(int m, logic [4:0] v);
      return (m == 2) ? 1'b0 : v[0];
   endfunction

   function automatic logic f_dut(int m, logic [4:0] v);
      if (m == 2) return 1'b1;
      if (m == 1) return v[0] ^ (v == 5'd19);
      return v[0];
   endfunction

   assign ref1 = f_ref(mode1, vec1);
   assign dut1 = f_dut(mode1, vec1);
   assign ref3 = f_ref(mode3, vec3);
   assign dut3 = f_dut(mode3, vec3);

   truth_sweep_ctrl #(.K(5), .SETTLE(1)) u_dut1 (
      .clk(clk), .reset(reset), .start(start1), .abort(abort1), .vec(vec1),
      .ref_in(ref1), .dut_in(dut1), .busy(busy1), .done(done1),
      .mismatch_cnt(mis1), .ones_cnt(ones1), .any_bad(any_bad1), .first_bad(first_bad1));

   truth_sweep_ctrl #(.K(5), .SETTLE(3)) u_dut3 (
      .clk(clk), .reset(reset), .start(start3), .abort(abort3), .vec(vec3),
      .ref_in(ref3), .dut_in(dut3), .busy(busy3), .done(done3),
      .mismatch_cnt(mis3), .ones_cnt(ones3), .any_bad(any_bad3), .first_bad(first_bad3));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs dut1 from a busy cycle to completion; reports busy length and done pulses seen.
   task automatic finish_sweep1(output int busy_cyc, output int done_cnt);
      busy_cyc = 0;
      done_cnt = 0;
      for (int n = 0; n < 200; n++) begin
         if (!busy1) break;
         busy_cyc++;
         tick();
      end
      for (int j = 0; j < 4; j++) begin
         if (done1) done_cnt++;
         tick();
      end
   endtask

   task automatic test_reset();
      bit found;
      n_checks++; if ({vec1, busy1, done1, mis1, ones1, any_bad1, first_bad1} !== 25'd0) begin n_fail++; $display("FAIL reset_hold: got %h want 0", {vec1, busy1, done1, mis1, ones1, any_bad1, first_bad1}); end
      reset = 1'b0;
      tick();
      n_checks++; if ({vec1, busy1, done1, mis1, ones1} !== 19'd0) begin n_fail++; $display("FAIL reset_release: got %h want 0", {vec1, busy1, done1, mis1, ones1}); end
      mode1 = 0;
      start1 = 1'b1; tick(); start1 = 1'b0;
      found = 1'b0;
      for (int n = 0; n < 100; n++) begin
         if (vec1 == 5'd12) begin found = 1'b1; break; end
         tick();
      end
      n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL reset_reach12: got %0d want 1", found); end
      n_checks++; if (ones1 !== 6'd6) begin n_fail++; $display("FAIL reset_partial_ones: got %0d want 6", ones1); end
      #1 reset = 1'b1;
      #1;
      n_checks++; if ({vec1, busy1, done1, mis1, ones1, any_bad1, first_bad1} !== 25'd0) begin n_fail++; $display("FAIL reset_midsweep: got %h want 0", {vec1, busy1, done1, mis1, ones1, any_bad1, first_bad1}); end
      @(posedge clk); #2 reset = 1'b0;
      tick();
   endtask

   task automatic test_clean_sweep();
      int bc, dc;
      mode1 = 0;
      start1 = 1'b1; tick(); start1 = 1'b0;
      n_checks++; if ({busy1, vec1} !== 6'b1_00000) begin n_fail++; $display("FAIL clean_start: got busy=%b vec=%0d want busy=1 vec=0", busy1, vec1); end
      finish_sweep1(bc, dc);
      n_checks++; if (bc !== 32) begin n_fail++; $display("FAIL clean_busy_len: got %0d want 32", bc); end
      n_checks++; if (dc !== 1) begin n_fail++; $display("FAIL clean_done_cnt: got %0d want 1", dc); end
      n_checks++; if (mis1 !== 6'd0) begin n_fail++; $display("FAIL clean_mismatch: got %0d want 0", mis1); end
      n_checks++; if (any_bad1 !== 1'b0) begin n_fail++; $display("FAIL clean_any_bad: got %0d want 0", any_bad1); end
      n_checks++; if (ones1 !== 6'd16) begin n_fail++; $display("FAIL clean_ones: got %0d want 16", ones1); end
      n_checks++; if (vec1 !== 5'd0) begin n_fail++; $display("FAIL clean_vec_idle: got %0d want 0", vec1); end
   endtask

   task automatic test_single_bad();
      int bc, dc;
      mode1 = 1;
      start1 = 1'b1; tick(); start1 = 1'b0;
      finish_sweep1(bc, dc);
      n_checks++; if (dc !== 1) begin n_fail++; $display("FAIL single_done_cnt: got %0d want 1", dc); end
      n_checks++; if (mis1 !== 6'd1) begin n_fail++; $display("FAIL single_mismatch: got %0d want 1", mis1); end
      n_checks++; if (any_bad1 !== 1'b1) begin n_fail++; $display("FAIL single_any_bad: got %0d want 1", any_bad1); end
      n_checks++; if (first_bad1 !== 5'd19) begin n_fail++; $display("FAIL single_first_bad: got %0d want 19", first_bad1); end
      n_checks++; if (ones1 !== 6'd16) begin n_fail++; $display("FAIL single_ones: got %0d want 16", ones1); end
   endtask

   task automatic test_all_bad();
      int bc, dc;
      mode1 = 2;
      start1 = 1'b1; tick(); start1 = 1'b0;
      finish_sweep1(bc, dc);
      n_checks++; if (mis1 !== 6'd32) begin n_fail++; $display("FAIL allbad_mismatch: got %0d want 32", mis1); end
      n_checks++; if (first_bad1 !== 5'd0) begin n_fail++; $display("FAIL allbad_first_bad: got %0d want 0", first_bad1); end
      n_checks++; if (ones1 !== 6'd0) begin n_fail++; $display("FAIL allbad_ones: got %0d want 0", ones1); end
      n_checks++; if (any_bad1 !== 1'b1) begin n_fail++; $display("FAIL allbad_any_bad: got %0d want 1", any_bad1); end
   endtask

   task automatic test_settle3();
      int dcnt;
      mode3 = 1;
      start3 = 1'b1; tick(); start3 = 1'b0;
      for (int i = 0; i < 96; i++) begin
         n_checks++; if ({busy3, vec3} !== {1'b1, 5'(i / 3)}) begin n_fail++; $display("FAIL s3_vec_cycle%0d: got busy=%b vec=%0d want busy=1 vec=%0d", i, busy3, vec3, i / 3); end
         start3 = (i == 40);
         tick();
      end
      dcnt = 0;
      n_checks++; if (busy3 !== 1'b0) begin n_fail++; $display("FAIL s3_busy_end: got %0d want 0", busy3); end
      for (int j = 0; j < 8; j++) begin
         if (done3) dcnt++;
         tick();
      end
      n_checks++; if (dcnt !== 1) begin n_fail++; $display("FAIL s3_done_cnt: got %0d want 1", dcnt); end
      n_checks++; if ({mis3, ones3, any_bad3, first_bad3} !== {6'd1, 6'd16, 1'b1, 5'd19}) begin n_fail++; $display("FAIL s3_totals: got mis=%0d ones=%0d bad=%0d first=%0d want 1 16 1 19", mis3, ones3, any_bad3, first_bad3); end
   endtask

   task automatic test_abort();
      int bc, dc;
      bit found;
      mode1 = 2;
      start1 = 1'b1; tick(); start1 = 1'b0;
      found = 1'b0;
      for (int n = 0; n < 100; n++) begin
         if (vec1 == 5'd10) begin found = 1'b1; break; end
         tick();
      end
      n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL abort_reach10: got %0d want 1", found); end
      abort1 = 1'b1; start1 = 1'b1; tick(); abort1 = 1'b0; start1 = 1'b0;
      n_checks++; if ({busy1, vec1, done1} !== 7'd0) begin n_fail++; $display("FAIL abort_idle: got busy=%b vec=%0d done=%b want 0 0 0", busy1, vec1, done1); end
      n_checks++; if ({mis1, ones1, any_bad1, first_bad1} !== {6'd10, 6'd0, 1'b1, 5'd0}) begin n_fail++; $display("FAIL abort_partial: got mis=%0d ones=%0d bad=%0d first=%0d want 10 0 1 0", mis1, ones1, any_bad1, first_bad1); end
      tick();
      n_checks++; if ({busy1, done1, mis1} !== {1'b0, 1'b0, 6'd10}) begin n_fail++; $display("FAIL abort_frozen: got busy=%b done=%b mis=%0d want 0 0 10", busy1, done1, mis1); end
      mode1 = 1;
      start1 = 1'b1; tick(); start1 = 1'b0;
      n_checks++; if ({busy1, mis1, ones1, any_bad1} !== {1'b1, 6'd0, 6'd0, 1'b0}) begin n_fail++; $display("FAIL abort_restart_clear: got busy=%b mis=%0d ones=%0d bad=%b want 1 0 0 0", busy1, mis1, ones1, any_bad1); end
      finish_sweep1(bc, dc);
      n_checks++; if ({bc, dc} !== {32'd32, 32'd1}) begin n_fail++; $display("FAIL abort_restart_len: got busy=%0d done=%0d want 32 1", bc, dc); end
      n_checks++; if ({mis1, ones1, any_bad1, first_bad1} !== {6'd1, 6'd16, 1'b1, 5'd19}) begin n_fail++; $display("FAIL abort_restart_totals: got mis=%0d ones=%0d bad=%0d first=%0d want 1 16 1 19", mis1, ones1, any_bad1, first_bad1); end
   endtask

   task automatic test_back_to_back();
      int bc, dc;
      int cyc;
      mode1 = 0;
      start1 = 1'b1; tick();
      cyc = 0;
      for (int n = 0; n < 100; n++) begin
         if (!busy1) break;
         cyc++;
         tick();
      end
      n_checks++; if ({cyc, done1} !== {32'd32, 1'b1}) begin n_fail++; $display("FAIL b2b_first: got busy=%0d done=%b want 32 1", cyc, done1); end
      tick();
      n_checks++; if ({busy1, done1} !== 2'b00) begin n_fail++; $display("FAIL b2b_idle_gap: got busy=%b done=%b want 0 0", busy1, done1); end
      tick();
      start1 = 1'b0;
      n_checks++; if ({busy1, vec1, ones1} !== {1'b1, 5'd0, 6'd0}) begin n_fail++; $display("FAIL b2b_restart: got busy=%b vec=%0d ones=%0d want 1 0 0", busy1, vec1, ones1); end
      finish_sweep1(bc, dc);
      n_checks++; if ({bc, ones1} !== {32'd32, 6'd16}) begin n_fail++; $display("FAIL b2b_second: got busy=%0d ones=%0d want 32 16", bc, ones1); end
   endtask

   initial begin
      reset = 1'b1;
      start1 = 1'b0; abort1 = 1'b0; start3 = 1'b0; abort3 = 1'b0;
      mode1 = 0; mode3 = 0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_clean_sweep();
      test_single_bad();
      test_all_bad();
      test_settle3();
      test_abort();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
